// File: rtl/alu_pkg.sv
// Shared widths, flag bit positions and the buffered writeback entry layout
// for the ALU writeback path.
package alu_pkg;

    localparam int DATA_W = 24;
    localparam int RD_W   = 3;

    localparam int FLAG_Z = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_C = 2;
    localparam int FLAG_V = 3;

    typedef struct packed {
        logic [DATA_W-1:0] result;
        logic              zero;
        logic              overflow;
        logic              carry;
        logic              neg;
        logic [RD_W-1:0]   rd;
        logic              flags_we;
    } wb_entry_t;

    localparam int ENTRY_W = $bits(wb_entry_t);

    // Negative flag is the sign bit of the two's-complement result.
    function automatic logic result_neg(input logic [DATA_W-1:0] res);
        return res[DATA_W-1];
    endfunction

endpackage

// File: rtl/wb_fifo2.sv
// Two-entry in-order buffer with 1-bit pointers, registered ready/valid and flush.
// Caller must only push when in_ready is high and pop when wb_valid is high.
module wb_fifo2
    import alu_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               push,
    input  logic [ENTRY_W-1:0] push_entry,
    input  logic               pop,
    output logic [ENTRY_W-1:0] head_entry,
    output logic               in_ready,
    output logic               wb_valid
);

    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] ONE   = 2'd1;
    localparam logic [1:0] FULL  = 2'd2;

    logic [ENTRY_W-1:0] mem_q [0:1];
    logic [1:0]         count_q, count_d;
    logic               wr_ptr_q, wr_ptr_d;
    logic               rd_ptr_q, rd_ptr_d;
    logic               in_ready_q;
    logic               wb_valid_q;
    logic               do_push;

    assign do_push = push && (count_q != FULL) && !flush;

    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            // Whatever is popped this cycle has already been consumed upstream
            // of the flush; the buffer restarts from a clean pointer pair.
            count_d  = EMPTY;
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
        end else begin
            if (do_push) wr_ptr_d = ~wr_ptr_q;
            if (pop)     rd_ptr_d = ~rd_ptr_q;
            case (count_q)
                EMPTY: begin
                    if (do_push) count_d = ONE;
                end
                ONE: begin
                    if (do_push && !pop)      count_d = FULL;
                    else if (!do_push && pop) count_d = EMPTY;
                end
                FULL: begin
                    if (pop) count_d = ONE;
                end
                default: count_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q    <= EMPTY;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            in_ready_q <= 1'b1;
            wb_valid_q <= 1'b0;
            mem_q[0]   <= '0;
            mem_q[1]   <= '0;
        end else begin
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            in_ready_q <= (count_d != FULL);
            wb_valid_q <= (count_d != EMPTY);
            if (do_push) mem_q[wr_ptr_q] <= push_entry;
        end
    end

    assign head_entry = mem_q[rd_ptr_q];
    assign in_ready   = in_ready_q;
    assign wb_valid   = wb_valid_q;

endmodule

// File: rtl/alu_writeback_stage.sv
// Buffers ALU results for the register-file write port and commits status flags on pop.
// One cycle push-to-present; holds up to two entries, in_ready drops when full.
module alu_writeback_stage
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_result,
    input  logic              in_zero,
    input  logic              in_overflow,
    input  logic              in_carry,
    input  logic [RD_W-1:0]   in_rd,
    input  logic              in_flags_we,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic [RD_W-1:0]   wb_rd,
    output logic [DATA_W-1:0] wb_data,
    output logic              flag_z,
    output logic              flag_n,
    output logic              flag_c,
    output logic              flag_v
);

    wb_entry_t          in_entry;
    wb_entry_t          head;
    logic [ENTRY_W-1:0] head_raw;
    logic               push;
    logic               pop;
    logic [3:0]         flags_q, flags_d;

    always_comb begin
        in_entry          = '0;
        in_entry.result   = in_result;
        in_entry.zero     = in_zero;
        in_entry.overflow = in_overflow;
        in_entry.carry    = in_carry;
        in_entry.neg      = result_neg(in_result);
        in_entry.rd       = in_rd;
        in_entry.flags_we = in_flags_we;
    end

    assign push = in_valid && in_ready;
    assign pop  = wb_valid && wb_ready;

    wb_fifo2 u_fifo (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .push       (push),
        .push_entry (in_entry),
        .pop        (pop),
        .head_entry (head_raw),
        .in_ready   (in_ready),
        .wb_valid   (wb_valid)
    );

    assign head = wb_entry_t'(head_raw);

    // A pop in a flush cycle still commits its flags.
    always_comb begin
        flags_d = flags_q;
        if (pop && head.flags_we) begin
            flags_d[FLAG_Z] = head.zero;
            flags_d[FLAG_N] = head.neg;
            flags_d[FLAG_C] = head.carry;
            flags_d[FLAG_V] = head.overflow;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) flags_q <= '0;
        else       flags_q <= flags_d;
    end

    assign wb_rd   = head.rd;
    assign wb_data = head.result;
    assign flag_z  = flags_q[FLAG_Z];
    assign flag_n  = flags_q[FLAG_N];
    assign flag_c  = flags_q[FLAG_C];
    assign flag_v  = flags_q[FLAG_V];

endmodule

// File: doc/alu_writeback_stage.md
# alu_writeback_stage

Registered stage directly downstream of the 24-bit ALU. It captures each ALU result together with its Zero/Overflow/CarryOut flags and destination register index into a 2-entry buffer. It presents entries to the register-file write port through a valid/ready handshake. On every committed write it updates the architectural status flags (Z, N, C, V).

## Interface
- DATA_W, 24, ALU result / register width
- RD_W, 3, destination register index width (8 registers)
- clk  in  1  rising-edge clock; single clock domain
- reset  in  1  synchronous, active-high; sampled on rising clk
- flush  in  1  synchronous discard of all buffered entries; flags untouched
- in_valid  in  1  ALU output holds a valid result
- in_ready  out  1  stage can accept; registered, equals (count != 2)
- in_result  in  DATA_W  ALU Result
- in_zero  in  1  ALU Zero
- in_overflow  in  1  ALU Overflow
- in_carry  in  1  ALU CarryOut
- in_rd  in  RD_W  destination register index
- in_flags_we  in  1  this instruction updates status flags
- wb_valid  out  1  head entry valid
- wb_ready  in  1  register file accepts head entry
- wb_rd  out  RD_W  head destination index
- wb_data  out  DATA_W  head result
- flag_z, flag_n, flag_c, flag_v  out  1 each  architectural status flags

## Operation
- Push: in_valid & in_ready at a rising edge. Pop: wb_valid & wb_ready at a rising edge.
- The buffer is a 2-entry in-order FIFO with states EMPTY (count 0), ONE (count 1) and FULL (count 2).
  - EMPTY: push → ONE.
  - ONE: push-only → FULL; pop-only → EMPTY; push+pop → ONE, and the new entry becomes head.
  - FULL: pop → ONE. No push is possible because in_ready is 0.
- Each entry stores {result, zero, overflow, carry, rd, flags_we}.
- N = result[23]. It is computed at push time and stored.
- Flags update only on pop of an entry with flags_we=1: flag_z←zero, flag_n←N, flag_c←carry, flag_v←overflow.
  - An entry with flags_we=0 leaves all four flags unchanged.
- flush forces count to 0 (EMPTY) at the next edge.
  - Any pop occurring that same cycle is still honoured and updates the flags.
  - A push in that same cycle is dropped.
- Priority: reset > flush > push/pop.
- in_valid while in_ready=0 is ignored. The upstream must hold data, and the stage captures nothing.
- wb_data, wb_rd and wb_valid must stay stable while wb_valid=1 and wb_ready=0.
- Pointers wrap modulo 2: 1-bit read and write pointers, toggled on pop and push respectively.

## Timing
- Reset values:
  - in_ready=1 (one cycle after reset deasserts, it reflects EMPTY).
  - wb_valid=0, wb_rd=0, wb_data=0.
  - flag_z=0, flag_n=0, flag_c=0, flag_v=0.
  - count=0, both pointers 0.
- Latency: an entry pushed at edge k is presented (wb_valid=1) after edge k; earliest pop is at edge k+1. There is no combinational path from the in_* data ports to the wb_* ports.
- Flags change at the same edge as the qualifying pop and are visible after that edge.
- Throughput: 1 entry/cycle sustained when wb_ready is held high.
- With wb_ready low, exactly 2 entries are absorbed, then in_ready drops after the second push edge.
- in_ready and wb_valid are both pure register outputs. No ready→ready or valid→valid combinational path exists.

## Structure
- Shared package alu_pkg:
  - DATA_W and RD_W constants.
  - Flag index constants FLAG_Z=0, FLAG_N=1, FLAG_C=2, FLAG_V=3.
  - A wb_entry_t struct {result, zero, overflow, carry, neg, rd, flags_we}.
- One natural sub-module: wb_fifo2, the 2-entry storage with pointers, count and flush.
- The top level adds push/pop qualification, N generation and the 4-bit flags register.

## Test plan
- Reset then single push (result=24'h800000, rd=5, carry=1, flags_we=1) with wb_ready=1 → wb_valid is 1 one cycle later with wb_data=24'h800000, wb_rd=5. After pop: flag_n=1, flag_c=1, flag_z=0, flag_v=0.
- wb_ready=0, push 3 back-to-back (24'h000001, 24'h000002, 24'h000003) → in_ready drops after the 2nd push and the 3rd is not captured. Then wb_ready=1 → outputs 24'h000001, then 24'h000002, in order, and wb_valid=0 afterwards.
- Stream 8 results with in_valid and wb_ready held high → 8 pops on 8 consecutive cycles; in_ready stays 1 throughout.
- Pop an entry with zero=1, flags_we=1, then pop one with result=24'h123456, flags_we=0 → flag_z stays 1 and the other flags are unchanged after the second pop.
- FULL buffer; assert flush and wb_ready in the same cycle → the head entry commits and updates the flags. The next cycle shows wb_valid=0 and in_ready=1. A push made in the flush cycle never appears.
- Reset asserted while FULL with flags all set → after the edge all outputs take their reset values, and the next push appears as the sole entry.
